// File: rtl/locking_rr_burst_arbiter_if.sv
// locking_rr_burst_arbiter_if: four request channels in, one merged channel out, plus arbiter status
interface locking_rr_burst_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 26,
  parameter int BEAT_W = 2
);
  logic [3:0]             in_valid;
  logic [3:0]             in_ready;
  logic [3:0][1:0]        in_src;
  logic [3:0][1:0]        in_dst;
  logic [3:0][ADDR_W-1:0] in_addr_block;
  logic [3:0][BEAT_W-1:0] in_addr_beat;
  logic [3:0][DATA_W-1:0] in_data;
  logic [3:0]             in_is_multibeat;
  logic                   out_ready;
  logic                   out_valid;
  logic [1:0]             out_src;
  logic [1:0]             out_dst;
  logic [ADDR_W-1:0]      out_addr_block;
  logic [BEAT_W-1:0]      out_addr_beat;
  logic [DATA_W-1:0]      out_data;
  logic                   out_is_multibeat;
  logic [1:0]             chosen;
  logic                   locked;
  logic [BEAT_W-1:0]      beat;

  modport slave (
    input  in_valid, in_src, in_dst, in_addr_block, in_addr_beat, in_data, in_is_multibeat, out_ready,
    output in_ready, out_valid, out_src, out_dst, out_addr_block, out_addr_beat, out_data,
           out_is_multibeat, chosen, locked, beat
  );

  modport master (
    output in_valid, in_src, in_dst, in_addr_block, in_addr_beat, in_data, in_is_multibeat, out_ready,
    input  in_ready, out_valid, out_src, out_dst, out_addr_block, out_addr_beat, out_data,
           out_is_multibeat, chosen, locked, beat
  );
endinterface

// File: rtl/locking_rr_burst_arbiter.sv
// locking_rr_burst_arbiter: 4-way round-robin arbiter that holds the grant for the whole of a multi-beat message
module locking_rr_burst_arbiter #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 2
) (
  input logic clk,
  input logic reset,
  locking_rr_burst_arbiter_if.slave io
);
  logic [1:0]        last_grant;
  logic [1:0]        lock_idx;
  logic [1:0]        arb_idx;
  logic [1:0]        chosen;
  logic              locked;
  logic              fire;
  logic [BEAT_W-1:0] beat_cnt;

  // round-robin pick: lowest valid index above last_grant, else lowest valid, else 3
  always_comb begin
    arb_idx = 2'd3;
    for (int i = 3; i >= 0; i--) if (io.in_valid[i]) arb_idx = 2'(i);
    for (int i = 3; i >= 0; i--) if (io.in_valid[i] && 2'(i) > last_grant) arb_idx = 2'(i);
  end

  assign chosen              = locked ? lock_idx : arb_idx;
  assign fire                = io.out_valid & io.out_ready;
  assign io.chosen           = chosen;
  assign io.locked           = locked;
  assign io.beat             = beat_cnt;
  assign io.out_valid        = io.in_valid[chosen];
  assign io.out_src          = io.in_src[chosen];
  assign io.out_dst          = io.in_dst[chosen];
  assign io.out_addr_block   = io.in_addr_block[chosen];
  assign io.out_addr_beat    = io.in_addr_beat[chosen];
  assign io.out_data         = io.in_data[chosen];
  assign io.out_is_multibeat = io.in_is_multibeat[chosen];
  assign io.in_ready         = io.out_ready ? 4'b0001 << chosen : 4'b0000;

  // grant history and burst lock; only a transfer moves state
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= '0;
      locked     <= 1'b0;
      lock_idx   <= '0;
      beat_cnt   <= '0;
    end else if (fire) begin
      if (!locked) begin
        last_grant <= chosen;
        if (io.in_is_multibeat[chosen]) begin
          locked   <= 1'b1;
          lock_idx <= chosen;
          beat_cnt <= BEAT_W'(1);
        end
      end else if (beat_cnt == BEAT_W'(BEATS - 1)) begin
        locked   <= 1'b0;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_locking_rr_burst_arbiter.sv
// tb_locking_rr_burst_arbiter: directed and random stimulus checked against a queue-free behavioural model
module tb_locking_rr_burst_arbiter;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int m_last = 0;
  int m_owner = -1;
  int m_left = 0;
  int obs_ch;

  locking_rr_burst_arbiter_if #(.DATA_W(64), .ADDR_W(26), .BEAT_W(BEAT_W)) bus ();
  locking_rr_burst_arbiter #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (.clk(clk), .reset(reset), .io(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return 3;
  endfunction

  task automatic step(input logic [3:0] v, input logic [3:0] mb, input logic ordy, input logic rst);
    int c;
    logic fire;
    @(negedge clk);
    reset = rst;
    bus.in_valid = v;
    bus.in_is_multibeat = mb;
    bus.out_ready = ordy;
    for (int i = 0; i < 4; i++) begin
      bus.in_data[i] = {$urandom, $urandom};
      bus.in_src[i] = 2'($urandom);
      bus.in_dst[i] = 2'($urandom);
      bus.in_addr_block[i] = 26'($urandom);
      bus.in_addr_beat[i] = 2'($urandom);
    end
    #1;
    c = m_owner >= 0 ? m_owner : rr_pick(v, m_last);
    obs_ch = int'(bus.chosen);
    check("chosen", bus.chosen, c);
    check("out_valid", bus.out_valid, v[c]);
    check("locked", bus.locked, m_owner >= 0);
    check("beat", bus.beat, m_owner >= 0 ? BEATS - m_left : 0);
    check("in_ready", bus.in_ready, ordy ? (1 << c) : 0);
    check("data", bus.out_data, bus.in_data[c]);
    check("bits", {bus.out_src, bus.out_dst, bus.out_addr_block, bus.out_addr_beat, bus.out_is_multibeat},
          {bus.in_src[c], bus.in_dst[c], bus.in_addr_block[c], bus.in_addr_beat[c], mb[c]});
    fire = v[c] && ordy;
    if (rst) begin
      m_last = 0;
      m_owner = -1;
      m_left = 0;
    end else if (fire) begin
      if (m_owner < 0) begin
        m_last = c;
        if (mb[c]) begin
          m_owner = c;
          m_left = BEATS - 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_owner = -1;
      end
    end
  endtask

  initial begin
    int seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    bus.in_valid = '0;
    bus.in_is_multibeat = '0;
    bus.out_ready = 1'b1;
    bus.in_data = '0;
    bus.in_src = '0;
    bus.in_dst = '0;
    bus.in_addr_block = '0;
    bus.in_addr_beat = '0;
    repeat (2) @(posedge clk);
    // idle after reset: nothing valid, index 3 selected
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    check("rst_chosen", bus.chosen, 3);
    check("rst_ready", bus.in_ready, 4'b1000);
    check("rst_locked", {bus.locked, bus.beat}, 0);
    // single-beat rotation from lastGrant=0
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'b0000, 1'b1, 1'b0);
      check("rr_seq", obs_ch, seq[i]);
    end
    // in2 burst beats in0 with lastGrant=1, in0 waits four beats
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0101, 4'b0100, 1'b1, 1'b0);
    check("burst_win", obs_ch, 2);
    for (int i = 1; i < BEATS; i++) begin
      step(4'b0101, 4'b0001, 1'b1, 1'b0);
      check("burst_beat", bus.beat, i);
      check("burst_block0", bus.in_ready[0], 1'b0);
    end
    step(4'b0101, 4'b0000, 1'b1, 1'b0);
    check("after_burst", obs_ch, 0);
    // owner bubble holds the lock against in3
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    step(4'b0010, 4'b0010, 1'b1, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    repeat (3) begin
      step(4'b1000, 4'b0000, 1'b1, 1'b0);
      check("bubble_valid", bus.out_valid, 1'b0);
      check("bubble_beat", bus.beat, 2);
    end
    repeat (2) step(4'b1010, 4'b0000, 1'b1, 1'b0);
    step(4'b1010, 4'b0000, 1'b1, 1'b0);
    check("bubble_release", obs_ch, 3);
    // back-pressure mid-burst freezes state
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    repeat (5) begin
      step(4'b1111, 4'($urandom), 1'b0, 1'b0);
      check("bp_beat", bus.beat, 1);
    end
    repeat (4) step(4'b1111, 4'b0000, 1'b1, 1'b0);
    // reset in the middle of an in3 burst
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    step(4'b1000, 4'b1000, 1'b1, 1'b0);
    step(4'b1000, 4'b0000, 1'b1, 1'b0);
    step(4'b1111, 4'b0000, 1'b1, 1'b1);
    check("mid_rst_beat", bus.beat, 2);
    step(4'b1111, 4'b0000, 1'b1, 1'b0);
    check("post_rst_locked", bus.locked, 1'b0);
    check("post_rst_chosen", obs_ch, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] mb;
      for (int k = 0; k < 4; k++) mb[k] = ($urandom_range(0, 9) < 3);
      step(4'($urandom), mb, $urandom_range(0, 9) < 8, $urandom_range(0, 199) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/locking_rr_burst_arbiter.md
Name: locking_rr_burst_arbiter

Overview:
- 4-input round-robin arbiter for multi-beat messages on the coherence network's outgoing grant/data channel.
- When a multi-beat message wins, the grant is locked to that input until BEATS beats have transferred, so beats from different sources never interleave.
- Single-beat messages arbitrate every transfer, with round-robin fairness.
- Sits between per-agent grant queues and the shared network output port.

Parameters:
- BEATS, 4, beats per multi-beat message; power of 2, ≥2
- BEAT_W, 2, log2(BEATS); width of the beat counter and addr_beat fields
- DATA_W, 64, payload data width
- ADDR_W, 26, addr_block width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- io_in_N_valid  in  1  (N=0..3) requester N has a beat
- io_in_N_ready  out  1  (N=0..3) beat of requester N accepted this cycle
- io_in_N_bits_header_src  in  2  (N=0..3) source id
- io_in_N_bits_header_dst  in  2  (N=0..3) destination id
- io_in_N_bits_payload_addr_block  in  ADDR_W  (N=0..3) block address
- io_in_N_bits_payload_addr_beat  in  BEAT_W  (N=0..3) beat index carried with the data
- io_in_N_bits_payload_data  in  DATA_W  (N=0..3) beat data
- io_in_N_bits_payload_is_multibeat  in  1  (N=0..3) 1 = message has BEATS beats
- io_out_ready  in  1  downstream accepts
- io_out_valid  out  1  selected input's valid
- io_out_bits_*  out  (same widths)  selected input's bits, all fields passed through unchanged
- io_chosen  out  2  index of the selected input
- io_locked  out  1  1 while a multi-beat message is in progress
- io_beat  out  BEAT_W  beat counter value; 0 when not locked

Behaviour:
- State: lastGrant[1:0], locked, lockIdx[1:0], beatCnt[BEAT_W-1:0].
- Reset values: lastGrant=0, locked=0, lockIdx=0, beatCnt=0.
- Arbitration when unlocked (combinational):
  - First priority: the lowest valid index i with i > lastGrant.
  - Otherwise: the lowest valid index.
  - If no input is valid: io_chosen=3 and io_out_valid=0.
- Selection when locked: io_chosen = lockIdx, regardless of which inputs are valid.
- Data path: io_out_valid and io_out_bits_* are a mux of the inputs on io_chosen. Zero cycles of latency; no buffering.
- Ready: io_in_N_ready = io_out_ready & (io_chosen==N).
  - A locked non-owner never sees ready.
  - Ready may be high while the corresponding valid is low; this is harmless.
- Fire: fire = io_out_valid & io_out_ready.
- Fire while unlocked:
  - lastGrant <= io_chosen.
  - If the selected is_multibeat=1: locked <= 1, lockIdx <= io_chosen, beatCnt <= 1.
  - Otherwise no lock is taken.
- Fire while locked:
  - If beatCnt == BEATS-1: locked <= 0, beatCnt <= 0. This is the last beat; the next cycle is unlocked.
  - Otherwise: beatCnt <= beatCnt+1.
- While locked:
  - lastGrant is not updated.
  - is_multibeat on subsequent beats is ignored.
  - addr_beat is passed through, not checked.
- Owner bubbles: if the lock owner drops valid while locked, io_out_valid=0 and the lock holds. Other inputs stay blocked indefinitely; there is no timeout.
- Back-pressure: io_out_ready=0 means no state change.
- Wrap-around: lastGrant=3 means the first-priority set is empty, so selection falls to the lowest valid index.
- io_locked = locked; io_beat = beatCnt.
- Reset mid-burst: the next cycle is unlocked with lastGrant=0. The remaining beats of the interrupted message are treated as new messages; the upstream queues are reset in the same domain.
- Release plus new request: the last beat fires in cycle T. In T+1 arbitration is unlocked with lastGrant = the old owner. Fairness: the old owner has the lowest priority in T+1.

Test Plan:
- Reset; all valid=0, io_out_ready=1 -> io_out_valid=0, io_chosen=3, io_locked=0, io_beat=0; in3_ready=1, in0..2_ready=0.
- All 4 inputs valid, single-beat, io_out_ready=1 held for 8 cycles -> io_chosen sequence 1,2,3,0,1,2,3,0 (lastGrant=0 after reset).
- in2 multibeat and in0 valid together, lastGrant=1 -> in2 wins; io_locked=1 for cycles 2..4; io_beat=1,2,3; in0_ready=0 for 4 beats; in0 fires on cycle 5.
- Locked on in1 at beatCnt=2: in1_valid=0 for 3 cycles, in3 valid -> io_out_valid=0, in3_ready=0, lock held; in1 resumes -> beats 2,3 complete, then in3 granted.
- io_out_ready=0 for 5 cycles mid-burst -> io_beat frozen and io_chosen stable; data of the selected input passes through unchanged.
- reset=1 for 1 cycle at io_beat=2 of an in3 burst, all inputs valid -> next cycle io_locked=0 and io_chosen=1 (lastGrant=0).
